// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates an active-low column strobe, synchronises the rows,
// debounces the first key seen and reports it as a code with a valid pulse and a held level.
module keypad_scanner #(
    parameter int SCAN_DIV_N     = 16,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED
    } state_t;

    logic [SCAN_DIV_N-1:0] div_reg;
    logic [1:0]            col_idx_reg;
    logic [3:0]            sync1_reg;
    logic [3:0]            sync2_reg;
    logic [3:0]            row_s;
    logic                  tick;

    state_t                state_reg;
    logic [3:0]            cand_reg;
    logic [CNT_W-1:0]      cnt_reg;

    logic                  hit;
    logic [1:0]            hit_row;
    logic                  cand_visit;
    logic                  cand_low;

    assign tick  = &div_reg;
    assign row_s = sync2_reg;

    // Divider, column rotation and row synchroniser run regardless of FSM state.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_reg     <= '0;
            col_idx_reg <= 2'd0;
            col         <= 4'b1110;
            sync1_reg   <= 4'b1111;
            sync2_reg   <= 4'b1111;
        end else begin
            div_reg   <= div_reg + 1'b1;
            sync1_reg <= row;
            sync2_reg <= sync1_reg;
            if (tick) begin
                col_idx_reg <= col_idx_reg + 2'd1;
                col         <= ~(4'b0001 << (col_idx_reg + 2'd1));
            end
        end
    end

    // Lowest-index low row wins when several keys share a column.
    always_comb begin
        hit_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!row_s[i]) begin
                hit_row = 2'(i);
            end
        end
    end

    assign hit        = (row_s != 4'b1111);
    assign cand_visit = tick && (col_idx_reg == cand_reg[1:0]);
    assign cand_low   = ~row_s[cand_reg[3:2]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SCAN;
            cand_reg  <= 4'd0;
            cnt_reg   <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state_reg)
                SCAN: begin
                    if (tick && hit) begin
                        cand_reg  <= {hit_row, col_idx_reg};
                        cnt_reg   <= CNT_ONE;
                        state_reg <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (cand_visit) begin
                        if (cand_low) begin
                            if (cnt_reg == CNT_LAST) begin
                                key_code  <= cand_reg;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                cnt_reg   <= '0;
                                state_reg <= PRESSED;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_ONE;
                            end
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= SCAN;
                        end
                    end
                end
                PRESSED: begin
                    // cnt_reg counts consecutive high samples; any low sample restarts release.
                    if (cand_visit) begin
                        if (cand_low) begin
                            cnt_reg <= '0;
                        end else if (cnt_reg == CNT_LAST) begin
                            key_held  <= 1'b0;
                            cnt_reg   <= '0;
                            state_reg <= SCAN;
                        end else begin
                            cnt_reg <= cnt_reg + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_reg <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a key_valid scoreboard.
module tb_keypad_scanner;

    localparam int DWELL = 4;
    localparam int DB    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed = '0;
    logic        prev_valid = 1'b0;
    int          checks = 0;
    int          failures = 0;
    longint      cyc = 0;
    longint      rel_cyc = 0;

    typedef struct {
        logic [3:0] code;
        longint     at;
    } exp_t;
    exp_t sb[$];

    keypad_scanner #(
        .SCAN_DIV_N(2),
        .DEBOUNCE_SCANS(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row(row),
        .col(col),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) begin
                    row[r] = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint k_now();
        return cyc - rel_cyc;
    endfunction

    task automatic wait_k(input longint t);
        while (k_now() < t) @(negedge clk);
    endtask

    // First tick of column c strictly after step kp, in steps since reset release.
    function automatic longint first_tick(input longint kp, input int c);
        for (longint t = kp + 1; t < kp + 64; t++) begin
            if (((t / DWELL) % 4) == c && (t % DWELL) == DWELL - 1) return t;
        end
        return kp + 64;
    endfunction

    function automatic longint next_frame(input int offset);
        return ((k_now() / 16) + 1) * 16 + offset;
    endfunction

    task automatic expect_press(input logic [3:0] code, input longint t1);
        exp_t e;
        e.code = code;
        e.at   = rel_cyc + t1 + 1 + (DB - 1) * 4 * DWELL;
        sb.push_back(e);
    endtask

    task automatic on_valid();
        exp_t e;
        check("valid_single", {63'd0, prev_valid}, 64'd0);
        check("valid_expected", {63'd0, sb.size() != 0}, 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("valid_code", {60'd0, key_code}, {60'd0, e.code});
            check("valid_cycle", cyc, e.at);
            $display("press code=%0d at cycle %0d", key_code, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid) on_valid();
        prev_valid <= key_valid;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        longint t1;
        longint kp;
        logic [3:0] ec;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_col", col, 4'b1110);
        check("reset_code", key_code, 0);
        check("reset_valid", key_valid, 0);
        check("reset_held", key_held, 0);
        reset = 1'b0;
        rel_cyc = cyc;

        // Idle rotation.
        for (int i = 0; i < 64; i++) begin
            wait_k(i);
            ec = 4'b1111 ^ (4'b0001 << ((i / DWELL) % 4));
            check("idle_col", col, ec);
            check("idle_held", key_held, 0);
            check("idle_code", key_code, 0);
        end
        $display("idle rotation done checks=%0d", checks);

        // Press and hold key 9 (row2/col1).
        wait_k(64);
        pressed[9] = 1'b1;
        t1 = first_tick(64, 1);
        expect_press(4'd9, t1);
        wait_k(t1 + 48);
        check("press9_held_early", key_held, 0);
        wait_k(t1 + 49);
        check("press9_held", key_held, 1);
        check("press9_code", key_code, 9);
        wait_k(t1 + 51);
        check("press9_delivered", sb.size(), 0);

        // Release key 9.
        kp = next_frame(0);
        wait_k(kp);
        pressed[9] = 1'b0;
        t1 = first_tick(kp, 1);
        wait_k(t1 + 48);
        check("rel9_held_before", key_held, 1);
        wait_k(t1 + 49);
        check("rel9_held_after", key_held, 0);
        check("rel9_code", key_code, 9);
        $display("release key 9 at cycle %0d", cyc);

        // Bounce on key 3 (row0/col3): two low visits then high.
        kp = next_frame(0);
        wait_k(kp);
        pressed[3] = 1'b1;
        t1 = first_tick(kp, 3);
        wait_k(t1 + 17);
        pressed[3] = 1'b0;
        wait_k(t1 + 40);
        check("bounce_code", key_code, 9);
        check("bounce_held", key_held, 0);
        $display("bounce key 3 rejected check at cycle %0d", cyc);

        // Keys 4 and 12 share column 0: lowest row wins.
        kp = next_frame(4);
        wait_k(kp);
        pressed[4] = 1'b1;
        pressed[12] = 1'b1;
        t1 = first_tick(kp, 0);
        expect_press(4'd4, t1);
        wait_k(t1 + 52);
        check("multi_held", key_held, 1);
        check("multi_code", key_code, 4);
        kp = next_frame(4);
        wait_k(kp);
        pressed[4] = 1'b0;
        pressed[12] = 1'b0;
        t1 = first_tick(kp, 0);
        wait_k(t1 + 48);
        check("multi_rel_before", key_held, 1);
        wait_k(t1 + 49);
        check("multi_rel_after", key_held, 0);
        check("multi_rel_code", key_code, 4);

        // Reset while key 9 is held.
        kp = next_frame(0);
        wait_k(kp);
        pressed[9] = 1'b1;
        t1 = first_tick(kp, 1);
        expect_press(4'd9, t1);
        wait_k(t1 + 60);
        check("prereset_held", key_held, 1);
        check("prereset_code", key_code, 9);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_col", col, 4'b1110);
        check("midreset_code", key_code, 0);
        check("midreset_held", key_held, 0);
        check("midreset_valid", key_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        rel_cyc = cyc;
        $display("reset released at cycle %0d", cyc);
        t1 = first_tick(0, 1);
        expect_press(4'd9, t1);
        wait_k(t1 + 48);
        check("repress_held_early", key_held, 0);
        check("repress_code_early", key_code, 0);
        wait_k(t1 + 49);
        check("repress_held", key_held, 1);
        check("repress_code", key_code, 9);

        pressed[9] = 1'b0;
        wait_k(t1 + 120);
        check("final_held", key_held, 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
